ps2_scan_ctrl: RTL and testbench

Sequencing controller between the ps2_keyboard receive FIFO and downstream consumers such as the display and CPU MMIO. It drains FIFO bytes with the ready/nextdata_n handshake and parses the 0xE0 (extended) and 0xF0 (break) prefixes. It emits one decoded key event per make/break over a valid/ready channel, tracks the held key, suppresses typematic repeats, and counts presses. It replaces ad-hoc polling of the FIFO by display/MMIO logic.

---
 rtl/ps2_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl
// Drains the ps2_keyboard receive FIFO one byte at a time and folds the
// E0 (extended) and F0 (break) prefixes into a single key event per
// make/break. Events go out through a one-entry valid/ready slot. The
// controller also tracks the currently held key, filters or flags typematic
// repeats, counts fresh presses and remembers FIFO overflow.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   kb_data         FIFO head byte
//   kb_ready        FIFO non-empty
//   kb_overflow     FIFO overflow flag
//   kb_nextdata_n   active-low pop strobe (one cycle per byte)
//   ev_valid/ready  event handshake
//   ev_code         scan code with prefixes stripped
//   ev_ext          event carried an E0 prefix
//   ev_release      1 = break, 0 = make
//   ev_repeat       make of the already-held key (SUPPRESS_REPEAT=0 only)
//   held_valid/code/ext  currently held key
//   press_cnt       count of non-repeat makes (wraps)
//   ovf_sticky      FIFO overflow seen since reset
module ps2_scan_ctrl #(
  parameter bit          SUPPRESS_REPEAT = 1'b1,
  parameter logic [15:0] PREFIX_TIMEOUT  = 16'd50000,
  parameter int          CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_release,
  output logic             ev_repeat,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      state_r;
  logic        ext_p_r;
  logic        brk_p_r;
  logic [15:0] tmo_cnt_r;

  logic pop_s, tmo_fire_s, flag_clr_s;
  logic ext_e_s, brk_e_s, ext_nx_s, brk_nx_s;
  logic is_e0_s, is_f0_s, is_err_s, is_code_s, match_s;
  logic emit_s, emit_rep_s, press_s, held_set_s, held_clr_s, tmo_run_s;

  // Pop decision, prefix bookkeeping and event classification for the byte at the FIFO head.
  always_comb begin
    pop_s      = (state_r == ST_IDLE) & kb_ready & (~ev_valid | ev_ready);
    tmo_fire_s = (tmo_cnt_r == PREFIX_TIMEOUT);
    tmo_run_s  = (ext_p_r | brk_p_r) & (state_r == ST_IDLE) & ~kb_ready;
    // Overflow or timeout wipes the prefixes before the popped byte is looked at,
    // so a byte arriving on the same edge sees clean flags and may set its own.
    flag_clr_s = kb_overflow | tmo_fire_s;
    ext_e_s    = ext_p_r & ~flag_clr_s;
    brk_e_s    = brk_p_r & ~flag_clr_s;
    is_e0_s    = (kb_data == 8'hE0);
    is_f0_s    = (kb_data == 8'hF0);
    is_err_s   = (kb_data == 8'h00) | (kb_data == 8'hFF);
    is_code_s  = pop_s & ~is_e0_s & ~is_f0_s & ~is_err_s;
    match_s    = held_valid & (held_ext == ext_e_s) & (held_code == kb_data);

    emit_s     = 1'b0;
    emit_rep_s = 1'b0;
    press_s    = 1'b0;
    held_set_s = 1'b0;
    held_clr_s = 1'b0;
    if (is_code_s) begin
      if (brk_e_s) begin
        emit_s     = 1'b1;
        held_clr_s = match_s;
      end else if (match_s) begin
        emit_s     = ~SUPPRESS_REPEAT;
        emit_rep_s = 1'b1;
      end else begin
        emit_s     = 1'b1;
        press_s    = 1'b1;
        held_set_s = 1'b1;
      end
    end else begin
      emit_s = 1'b0;
    end

    ext_nx_s = ext_e_s;
    brk_nx_s = brk_e_s;
    if (pop_s) begin
      if (is_e0_s) begin
        ext_nx_s = 1'b1;
      end else if (is_f0_s) begin
        brk_nx_s = 1'b1;
      end else begin
        // Error bytes and completed codes both leave no prefix pending.
        ext_nx_s = 1'b0;
        brk_nx_s = 1'b0;
      end
    end else begin
      ext_nx_s = ext_e_s;
      brk_nx_s = brk_e_s;
    end
  end

  // Fetch FSM, prefix flags, timeout, held-key tracking and the event output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      kb_nextdata_n <= 1'b1;
      ext_p_r       <= 1'b0;
      brk_p_r       <= 1'b0;
      tmo_cnt_r     <= 16'd0;
      ev_valid      <= 1'b0;
      ev_code       <= 8'h00;
      ev_ext        <= 1'b0;
      ev_release    <= 1'b0;
      ev_repeat     <= 1'b0;
      held_valid    <= 1'b0;
      held_code     <= 8'h00;
      held_ext      <= 1'b0;
      press_cnt     <= '0;
      ovf_sticky    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r       <= ST_POP;
            kb_nextdata_n <= 1'b0;
          end else begin
            state_r       <= ST_IDLE;
            kb_nextdata_n <= 1'b1;
          end
        end
        ST_POP: begin
          state_r       <= ST_GAP;
          kb_nextdata_n <= 1'b1;
        end
        ST_GAP: begin
          // Lets kb_ready settle to the advanced FIFO read pointer.
          state_r       <= ST_IDLE;
          kb_nextdata_n <= 1'b1;
        end
        default: begin
          state_r       <= ST_IDLE;
          kb_nextdata_n <= 1'b1;
        end
      endcase

      ext_p_r <= ext_nx_s;
      brk_p_r <= brk_nx_s;

      if (pop_s || tmo_fire_s) begin
        tmo_cnt_r <= 16'd0;
      end else if (tmo_run_s) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end

      if (kb_overflow) begin
        ovf_sticky <= 1'b1;
      end

      if (held_set_s) begin
        held_valid <= 1'b1;
        held_code  <= kb_data;
        held_ext   <= ext_e_s;
      end else if (held_clr_s) begin
        held_valid <= 1'b0;
      end

      if (press_s) begin
        press_cnt <= press_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      // A new event may load on the same edge the previous one is taken.
      if (emit_s) begin
        ev_valid   <= 1'b1;
        ev_code    <= kb_data;
        ev_ext     <= ext_e_s;
        ev_release <= brk_e_s;
        ev_repeat  <= emit_rep_s;
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
module tb_ps2_scan_ctrl;

  localparam logic [15:0] TMO = 16'd40;

  logic clk = 1'b0;
  logic rst, kb_overflow, ev_ready;
  logic [7:0] kb_data;
  logic kb_ready;

  // FIFO model shared by both DUTs; popped by the suppressing DUT's strobe.
  logic [7:0] fifo_mem [64];
  logic [6:0] wr_ptr = 7'd0;
  logic [6:0] rd_ptr = 7'd0;
  assign kb_ready = (wr_ptr != rd_ptr);
  assign kb_data  = fifo_mem[rd_ptr[5:0]];

  logic       nd1_n, v1, ext1, rel1, rep1, hv1, hx1, ovf1;
  logic [7:0] code1, hc1, cnt1;
  logic       nd2_n, v2, ext2, rel2, rep2, hv2, hx2, ovf2;
  logic [7:0] code2, hc2, cnt2;

  ps2_scan_ctrl #(.SUPPRESS_REPEAT(1'b1), .PREFIX_TIMEOUT(TMO), .CNT_W(8)) u_sup (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready), .kb_overflow(kb_overflow),
    .kb_nextdata_n(nd1_n), .ev_valid(v1), .ev_ready(ev_ready), .ev_code(code1), .ev_ext(ext1),
    .ev_release(rel1), .ev_repeat(rep1), .held_valid(hv1), .held_code(hc1), .held_ext(hx1),
    .press_cnt(cnt1), .ovf_sticky(ovf1));

  ps2_scan_ctrl #(.SUPPRESS_REPEAT(1'b0), .PREFIX_TIMEOUT(TMO), .CNT_W(8)) u_rep (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready), .kb_overflow(kb_overflow),
    .kb_nextdata_n(nd2_n), .ev_valid(v2), .ev_ready(ev_ready), .ev_code(code2), .ev_ext(ext2),
    .ev_release(rel2), .ev_repeat(rep2), .held_valid(hv2), .held_code(hc2), .held_ext(hx2),
    .press_cnt(cnt2), .ovf_sticky(ovf2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
  } ev_t;

  ev_t log1 [64];
  ev_t log2 [64];
  int  ev1_n = 0;
  int  ev2_n = 0;
  int  pop_n = 0;
  int  dbl_n = 0;
  logic prev_low = 1'b0;

  always @(posedge clk) begin
    if (!nd1_n && kb_ready) rd_ptr <= rd_ptr + 7'd1;
    if (!nd1_n) pop_n <= pop_n + 1;
    if (!nd1_n && prev_low) dbl_n <= dbl_n + 1;
    prev_low <= !nd1_n;
    if (v1 && ev_ready) begin
      log1[ev1_n % 64] <= '{code1, ext1, rel1, rep1};
      ev1_n <= ev1_n + 1;
    end
    if (v2 && ev_ready) begin
      log2[ev2_n % 64] <= '{code2, ext2, rel2, rep2};
      ev2_n <= ev2_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 7'd1;
  endtask

  task automatic settle();
    int k;
    k = 0;
    while (wr_ptr != rd_ptr && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_bound", (k < 100) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_outs"}, {v1, code1, ext1, rel1, rep1, hv1, hc1, hx1, ovf1, cnt1}, 32'd0);
    chk({name, "_nd"}, {31'd0, nd1_n}, 32'd1);
    chk({name, "_rep_outs"}, {v2, code2, hv2, hc2, ovf2, cnt2}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       ev1;
    logic       ev2;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep2;
    logic       held;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int n1, n2, p0;
    tbl[0]  = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[2]  = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[4]  = '{8'h75, 1'b1, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[5]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[6]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[7]  = '{8'h75, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[8]  = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[9]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3};
    tbl[10] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3};
    tbl[11] = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[12] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[14] = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[15] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[16] = '{8'h29, 1'b1, 1'b1, 8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
    tbl[17] = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
    tbl[18] = '{8'h29, 1'b1, 1'b1, 8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
    tbl[19] = '{8'h32, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5};
    tbl[20] = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5};
    tbl[21] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5};
    tbl[22] = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5};
    tbl[23] = '{8'h32, 1'b1, 1'b1, 8'h32, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};

    rst = 1'b1;
    kb_overflow = 1'b0;
    ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset_init");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      n1 = ev1_n;
      n2 = ev2_n;
      p0 = pop_n;
      push(tbl[i].b);
      settle();
      chk($sformatf("v%0d_ev_cnt", i), ev1_n - n1, {31'd0, tbl[i].ev1});
      if (tbl[i].ev1)
        chk($sformatf("v%0d_ev", i), {22'd0, log1[(ev1_n - 1) % 64]},
            {22'd0, tbl[i].code, tbl[i].ext, tbl[i].rel, 1'b0});
      chk($sformatf("v%0d_rep_ev_cnt", i), ev2_n - n2, {31'd0, tbl[i].ev2});
      if (tbl[i].ev2)
        chk($sformatf("v%0d_rep_ev", i), {22'd0, log2[(ev2_n - 1) % 64]},
            {22'd0, tbl[i].code, tbl[i].ext, tbl[i].rel, tbl[i].rep2});
      chk($sformatf("v%0d_held", i), {31'd0, hv1}, {31'd0, tbl[i].held});
      chk($sformatf("v%0d_cnt", i), {24'd0, cnt1}, {24'd0, tbl[i].cnt});
      chk($sformatf("v%0d_rep_cnt", i), {24'd0, cnt2}, {24'd0, tbl[i].cnt});
      chk($sformatf("v%0d_pops", i), pop_n - p0, 32'd1);
    end
    chk("single_cycle_pops", dbl_n, 32'd0);

    // Backpressure: slot full, second byte must stay in the FIFO.
    n1 = ev1_n;
    p0 = pop_n;
    ev_ready = 1'b0;
    push(8'h1C);
    push(8'h32);
    repeat (10) @(negedge clk);
    chk("bp_mid_code", {23'd0, v1, code1}, {23'd0, 1'b1, 8'h1C});
    repeat (10) @(negedge clk);
    chk("bp_end_code", {23'd0, v1, code1}, {23'd0, 1'b1, 8'h1C});
    chk("bp_pops", pop_n - p0, 32'd1);
    chk("bp_fifo_kept", {31'd0, kb_ready}, 32'd1);
    ev_ready = 1'b1;
    settle();
    chk("bp_ev_cnt", ev1_n - n1, 32'd2);
    chk("bp_first", {24'd0, log1[n1 % 64].code}, 32'h1C);
    chk("bp_second", {24'd0, log1[(n1 + 1) % 64].code}, 32'h32);
    chk("bp_cnt", {24'd0, cnt1}, 32'd7);

    // Pending break prefix expires, so the following code is a make.
    push(8'hF0);
    settle();
    repeat (int'(TMO) + 10) @(negedge clk);
    push(8'h1C);
    settle();
    chk("tmo_ev", {23'd0, log1[(ev1_n - 1) % 64].code, log1[(ev1_n - 1) % 64].rel}, {23'd0, 8'h1C, 1'b0});
    chk("tmo_cnt", {24'd0, cnt1}, 32'd8);
    chk("tmo_held", {23'd0, hv1, hc1}, {23'd0, 1'b1, 8'h1C});

    // Overflow drops a pending E0 and is remembered.
    push(8'hE0);
    settle();
    chk("ovf_before", {31'd0, ovf1}, 32'd0);
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    push(8'h29);
    settle();
    chk("ovf_sticky", {30'd0, ovf1, ovf2}, 32'd3);
    chk("ovf_ev", {23'd0, log1[(ev1_n - 1) % 64].code, log1[(ev1_n - 1) % 64].ext}, {23'd0, 8'h29, 1'b0});
    chk("ovf_cnt", {24'd0, cnt1}, 32'd9);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset_final");
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
